// File: rtl/pll_lock_rst_seq.sv
// -----------------------------------------------------------------------------
// pll_lock_rst_seq
//
// Lock supervisor and staged reset sequencer for the PLL wrapper. Runs on the
// free-running board clock that also feeds the PLL reference, so it never
// depends on a PLL output clock being alive.
//
// The raw lock flag is synchronised, then qualified for stability. Once it is
// stable, the three domain resets are released in order (bit0 first). If lock
// does not arrive within the timeout, the PLL reset is pulsed again and the
// retry counter is bumped. Losing lock after release drops all domain resets
// together in one cycle.
//
// Ports
//   clk        in   free-running board clock
//   rst        in   asynchronous active-high reset
//   pll_lock   in   raw PLL lock flag, asynchronous to clk
//   pll_rst    out  active-high reset to the PLL RST pin
//   rst_out_n  out  [2:0] staged domain resets, active low, bit0 released first
//   locked_ok  out  high while all stages are released and lock holds
//   retry_cnt  out  [3:0] lock-timeout retries, saturates at 15
//   state      out  [2:0] FSM state code, for debug
//
// Optional build macro PLL_LOCK_LOSS_CNT_EN adds:
//   lock_loss_cnt  out  [7:0] lock-loss events after release, saturates at 255
//   lock_loss_err  out  sticky flag, set on the first lock-loss event
//
// State table
//   state      | code | meaning
//   PLL_RST    | 0    | hold PLL in reset for PLL_RST_CYC cycles
//   WAIT_LOCK  | 1    | PLL running, waiting for lock, timeout counting
//   STABLE     | 2    | lock seen, counting consecutive lock-high cycles
//   RELEASE    | 3    | releasing domain resets one stage at a time
//   RUN        | 4    | all stages released, lock holding
// -----------------------------------------------------------------------------
module pll_lock_rst_seq #(
  parameter int PLL_RST_CYC      = 64,
  parameter int LOCK_TIMEOUT_CYC = 500000,
  parameter int LOCK_STABLE_CYC  = 1000,
  parameter int STAGE_GAP_CYC    = 16,
  parameter int CNT_W            = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic [2:0] rst_out_n,
  output logic       locked_ok,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt,
  output logic       lock_loss_err
`endif
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_e;

  // Every state compares against its limit minus one, so the counter never wraps.
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP      = CNT_W'(STAGE_GAP_CYC);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(2 * STAGE_GAP_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             pll_rst_q, pll_rst_d;
  logic [2:0]       rst_out_n_q, rst_out_n_d;
  logic             locked_ok_q, locked_ok_d;
  logic             sync1_q, lock_s_q;
  logic             loss_evt;

  // Two-flop synchroniser for the asynchronous lock flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  // State register. The outputs are registered here as well, from their
  // next-state values, so they change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      pll_rst_q   <= 1'b1;
      rst_out_n_q <= 3'b000;
      locked_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      rst_out_n_q <= rst_out_n_d;
      locked_ok_q <= locked_ok_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    loss_evt = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing in the same cycle.
        if (lock_s_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
          if (retry_q != 4'hF) begin
            retry_d = retry_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STABLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RELEASE: begin
        if (!lock_s_q) begin
          state_d  = S_WAIT_LOCK;
          cnt_d    = '0;
          loss_evt = 1'b1;
        end else if (cnt_q == REL_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        // The PLL is not reset here; a PLL that stays unlocked is caught by
        // the WAIT_LOCK timeout.
        if (!lock_s_q) begin
          state_d  = S_WAIT_LOCK;
          cnt_d    = '0;
          loss_evt = 1'b1;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with
  // the state they belong to. In RELEASE the counter is the number of cycles
  // since entry, which places stage 1 exactly STAGE_GAP_CYC cycles after
  // stage 0; stage 2 coincides with the move to RUN.
  always_comb begin
    pll_rst_d   = 1'b0;
    rst_out_n_d = 3'b000;
    locked_ok_d = 1'b0;
    case (state_d)
      S_PLL_RST: begin
        pll_rst_d = 1'b1;
      end
      S_RELEASE: begin
        rst_out_n_d[0] = 1'b1;
        rst_out_n_d[1] = (cnt_d >= GAP);
      end
      S_RUN: begin
        rst_out_n_d = 3'b111;
        locked_ok_d = 1'b1;
      end
      default: begin
        pll_rst_d = 1'b0;
      end
    endcase
  end

  assign pll_rst   = pll_rst_q;
  assign rst_out_n = rst_out_n_q;
  assign locked_ok = locked_ok_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;
  logic       loss_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt_q <= 8'd0;
      loss_err_q <= 1'b0;
    end else if (loss_evt) begin
      loss_err_q <= 1'b1;
      if (loss_cnt_q != 8'hFF) begin
        loss_cnt_q <= loss_cnt_q + 8'd1;
      end
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
  assign lock_loss_err = loss_err_q;
`else
  // Lock-loss events only feed the optional counter.
  logic unused_loss_evt;
  assign unused_loss_evt = loss_evt;
`endif

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_rst_seq
//
// Each vector resets the sequencer, drives a pll_lock waveform (rise cycle plus
// an optional low window), and checks all outputs at one chosen cycle. Cycle c
// is the c-th rising edge after rst is released; outputs are sampled 1 time
// unit after that edge. Expected records go into a scoreboard queue when a
// vector starts and are popped when its check cycle is reached.
// -----------------------------------------------------------------------------
module tb_pll_lock_rst_seq;

  localparam int NEVER = 1000000;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       pll_rst;
  logic [2:0] rst_out_n;
  logic       locked_ok;
  logic [3:0] retry_cnt;
  logic [2:0] state;
`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
  logic       lock_loss_err;
`endif

  pll_lock_rst_seq #(
    .PLL_RST_CYC      (4),
    .LOCK_TIMEOUT_CYC (100),
    .LOCK_STABLE_CYC  (8),
    .STAGE_GAP_CYC    (3),
    .CNT_W            (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .pll_rst   (pll_rst),
    .rst_out_n (rst_out_n),
    .locked_ok (locked_ok),
    .retry_cnt (retry_cnt),
    .state     (state)
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    .lock_loss_cnt (lock_loss_cnt),
    .lock_loss_err (lock_loss_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         lock_rise;
    int         gap_start;
    int         gap_len;
    int         chk;
    logic       pll_rst;
    logic [2:0] rst_n;
    logic       ok;
    logic [3:0] retry;
    logic [2:0] st;
    logic [7:0] llc;
    logic       lle;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(string n, int l, int gs, int gl, int chk,
                              logic pr, logic [2:0] rn, logic ok,
                              logic [3:0] rc, logic [2:0] st,
                              logic [7:0] llc, logic lle);
    vec_t v;
    v.name = n; v.lock_rise = l; v.gap_start = gs; v.gap_len = gl; v.chk = chk;
    v.pll_rst = pr; v.rst_n = rn; v.ok = ok; v.retry = rc; v.st = st;
    v.llc = llc; v.lle = lle;
    return v;
  endfunction

  function automatic logic lock_at(vec_t v, int c);
    return (c >= v.lock_rise) && !(c >= v.gap_start && c < v.gap_start + v.gap_len);
  endfunction

  task automatic cmp_now();
    vec_t  e;
    logic  bad;
    string extra;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard_empty: no expected record at time %0t", $time);
      return;
    end
    e = sb.pop_front();
    n_vec++;
    extra = "";
    bad = (pll_rst !== e.pll_rst) || (rst_out_n !== e.rst_n) || (locked_ok !== e.ok) ||
          (retry_cnt !== e.retry) || (state !== e.st);
`ifdef PLL_LOCK_LOSS_CNT_EN
    bad = bad || (lock_loss_cnt !== e.llc) || (lock_loss_err !== e.lle);
    extra = $sformatf(" llc=%0d/%0d lle=%b/%b", lock_loss_cnt, e.llc, lock_loss_err, e.lle);
`endif
    if (bad) begin
      n_miss++;
      $display("FAIL %s (got/exp): pll_rst=%b/%b rst_out_n=%b/%b locked_ok=%b/%b retry_cnt=%0d/%0d state=%0d/%0d%s",
               e.name, pll_rst, e.pll_rst, rst_out_n, e.rst_n, locked_ok, e.ok,
               retry_cnt, e.retry, state, e.st, extra);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    pll_lock = lock_at(v, 0);
    do_reset();
    sb.push_back(v);
    for (int c = 0; c <= v.chk; c++) begin
      @(negedge clk);
      pll_lock = lock_at(v, c);
      @(posedge clk);
      #1;
      if (c == v.chk) cmp_now();
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t v;
    rst      = 1'b1;
    pll_lock = 1'b0;

    // Nominal bring-up, lock from cycle 10.
    vecs.push_back(mk("nom_c0",   10, -1, 0,  0, 1'b1, 3'b000, 1'b0, 4'd0, 3'd0, 8'd0, 1'b0));
    vecs.push_back(mk("nom_c2",   10, -1, 0,  2, 1'b1, 3'b000, 1'b0, 4'd0, 3'd0, 8'd0, 1'b0));
    vecs.push_back(mk("nom_c3",   10, -1, 0,  3, 1'b0, 3'b000, 1'b0, 4'd0, 3'd1, 8'd0, 1'b0));
    vecs.push_back(mk("nom_c11",  10, -1, 0, 11, 1'b0, 3'b000, 1'b0, 4'd0, 3'd1, 8'd0, 1'b0));
    vecs.push_back(mk("nom_c12",  10, -1, 0, 12, 1'b0, 3'b000, 1'b0, 4'd0, 3'd2, 8'd0, 1'b0));
    vecs.push_back(mk("nom_c19",  10, -1, 0, 19, 1'b0, 3'b000, 1'b0, 4'd0, 3'd2, 8'd0, 1'b0));
    vecs.push_back(mk("nom_c20",  10, -1, 0, 20, 1'b0, 3'b001, 1'b0, 4'd0, 3'd3, 8'd0, 1'b0));
    vecs.push_back(mk("nom_c22",  10, -1, 0, 22, 1'b0, 3'b001, 1'b0, 4'd0, 3'd3, 8'd0, 1'b0));
    vecs.push_back(mk("nom_c23",  10, -1, 0, 23, 1'b0, 3'b011, 1'b0, 4'd0, 3'd3, 8'd0, 1'b0));
    vecs.push_back(mk("nom_c25",  10, -1, 0, 25, 1'b0, 3'b011, 1'b0, 4'd0, 3'd3, 8'd0, 1'b0));
    vecs.push_back(mk("nom_c26",  10, -1, 0, 26, 1'b0, 3'b111, 1'b1, 4'd0, 3'd4, 8'd0, 1'b0));
    vecs.push_back(mk("nom_c40",  10, -1, 0, 40, 1'b0, 3'b111, 1'b1, 4'd0, 3'd4, 8'd0, 1'b0));
    // Lock never arrives: timeout k lands on cycle 103 + 104*(k-1).
    vecs.push_back(mk("to_c102",  NEVER, -1, 0,  102, 1'b0, 3'b000, 1'b0, 4'd0,  3'd1, 8'd0, 1'b0));
    vecs.push_back(mk("to_c103",  NEVER, -1, 0,  103, 1'b1, 3'b000, 1'b0, 4'd1,  3'd0, 8'd0, 1'b0));
    vecs.push_back(mk("to_c106",  NEVER, -1, 0,  106, 1'b1, 3'b000, 1'b0, 4'd1,  3'd0, 8'd0, 1'b0));
    vecs.push_back(mk("to_c107",  NEVER, -1, 0,  107, 1'b0, 3'b000, 1'b0, 4'd1,  3'd1, 8'd0, 1'b0));
    vecs.push_back(mk("to_c207",  NEVER, -1, 0,  207, 1'b1, 3'b000, 1'b0, 4'd2,  3'd0, 8'd0, 1'b0));
    vecs.push_back(mk("to_c311",  NEVER, -1, 0,  311, 1'b1, 3'b000, 1'b0, 4'd3,  3'd0, 8'd0, 1'b0));
    vecs.push_back(mk("to_c1558", NEVER, -1, 0, 1558, 1'b0, 3'b000, 1'b0, 4'd14, 3'd1, 8'd0, 1'b0));
    vecs.push_back(mk("to_c1559", NEVER, -1, 0, 1559, 1'b1, 3'b000, 1'b0, 4'd15, 3'd0, 8'd0, 1'b0));
    vecs.push_back(mk("to_c1700", NEVER, -1, 0, 1700, 1'b0, 3'b000, 1'b0, 4'd15, 3'd1, 8'd0, 1'b0));
    vecs.push_back(mk("to_c1767", NEVER, -1, 0, 1767, 1'b1, 3'b000, 1'b0, 4'd15, 3'd0, 8'd0, 1'b0));
    // One-cycle lock glitch in STABLE (low on cycle 15).
    vecs.push_back(mk("gl_c16",   10, 15, 1, 16, 1'b0, 3'b000, 1'b0, 4'd0, 3'd2, 8'd0, 1'b0));
    vecs.push_back(mk("gl_c17",   10, 15, 1, 17, 1'b0, 3'b000, 1'b0, 4'd0, 3'd1, 8'd0, 1'b0));
    vecs.push_back(mk("gl_c18",   10, 15, 1, 18, 1'b0, 3'b000, 1'b0, 4'd0, 3'd2, 8'd0, 1'b0));
    vecs.push_back(mk("gl_c20",   10, 15, 1, 20, 1'b0, 3'b000, 1'b0, 4'd0, 3'd2, 8'd0, 1'b0));
    vecs.push_back(mk("gl_c25",   10, 15, 1, 25, 1'b0, 3'b000, 1'b0, 4'd0, 3'd2, 8'd0, 1'b0));
    vecs.push_back(mk("gl_c26",   10, 15, 1, 26, 1'b0, 3'b001, 1'b0, 4'd0, 3'd3, 8'd0, 1'b0));
    // Lock loss in RUN (low on cycles 40..49).
    vecs.push_back(mk("rl_c41",   10, 40, 10, 41, 1'b0, 3'b111, 1'b1, 4'd0, 3'd4, 8'd0, 1'b0));
    vecs.push_back(mk("rl_c42",   10, 40, 10, 42, 1'b0, 3'b000, 1'b0, 4'd0, 3'd1, 8'd1, 1'b1));
    vecs.push_back(mk("rl_c52",   10, 40, 10, 52, 1'b0, 3'b000, 1'b0, 4'd0, 3'd2, 8'd1, 1'b1));
    vecs.push_back(mk("rl_c60",   10, 40, 10, 60, 1'b0, 3'b001, 1'b0, 4'd0, 3'd3, 8'd1, 1'b1));
    vecs.push_back(mk("rl_c66",   10, 40, 10, 66, 1'b0, 3'b111, 1'b1, 4'd0, 3'd4, 8'd1, 1'b1));
    // Lock loss in RELEASE (low on cycles 22..29).
    vecs.push_back(mk("rel_c23",  10, 22, 8, 23, 1'b0, 3'b011, 1'b0, 4'd0, 3'd3, 8'd0, 1'b0));
    vecs.push_back(mk("rel_c24",  10, 22, 8, 24, 1'b0, 3'b000, 1'b0, 4'd0, 3'd1, 8'd1, 1'b1));
    vecs.push_back(mk("rel_c32",  10, 22, 8, 32, 1'b0, 3'b000, 1'b0, 4'd0, 3'd2, 8'd1, 1'b1));
    vecs.push_back(mk("rel_c40",  10, 22, 8, 40, 1'b0, 3'b001, 1'b0, 4'd0, 3'd3, 8'd1, 1'b1));
    // Lock arriving on the timeout cycle, and one cycle too late.
    vecs.push_back(mk("tmo101_c102", 101, -1, 0, 102, 1'b0, 3'b000, 1'b0, 4'd0, 3'd1, 8'd0, 1'b0));
    vecs.push_back(mk("tmo101_c103", 101, -1, 0, 103, 1'b0, 3'b000, 1'b0, 4'd0, 3'd2, 8'd0, 1'b0));
    vecs.push_back(mk("tmo101_c111", 101, -1, 0, 111, 1'b0, 3'b001, 1'b0, 4'd0, 3'd3, 8'd0, 1'b0));
    vecs.push_back(mk("tmo102_c103", 102, -1, 0, 103, 1'b1, 3'b000, 1'b0, 4'd1, 3'd0, 8'd0, 1'b0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Mid-release reset: reach rst_out_n=001, then assert rst between edges
    // and expect every output back at its reset value without a clock edge.
    v = mk("midrel_c21", 10, -1, 0, 21, 1'b0, 3'b001, 1'b0, 4'd0, 3'd3, 8'd0, 1'b0);
    run_vec(v);
    #2 rst = 1'b1;
    sb.push_back(mk("midrel_async", 0, -1, 0, 0, 1'b1, 3'b000, 1'b0, 4'd0, 3'd0, 8'd0, 1'b0));
    #1 cmp_now();

    // Clean sequence after release, with lock already high throughout.
    run_vec(mk("post_c3",  0, -1, 0,  3, 1'b0, 3'b000, 1'b0, 4'd0, 3'd1, 8'd0, 1'b0));
    run_vec(mk("post_c4",  0, -1, 0,  4, 1'b0, 3'b000, 1'b0, 4'd0, 3'd2, 8'd0, 1'b0));
    run_vec(mk("post_c12", 0, -1, 0, 12, 1'b0, 3'b001, 1'b0, 4'd0, 3'd3, 8'd0, 1'b0));
    run_vec(mk("post_c18", 0, -1, 0, 18, 1'b0, 3'b111, 1'b1, 4'd0, 3'd4, 8'd0, 1'b0));

    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_leftover: %0d records unchecked, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
